feature_frame_loader: RTL and testbench
=======================================

# feature_frame_loader

Upstream stage of the combinational classifier `top`. Accepts one WIDTH_A-bit feature per beat over a valid/ready stream, assembles NUM_A features into the flat `inp` vector, and holds it stable while the classifier settles. It then samples the classifier's `out` after a fixed settle count and presents the class as a valid/ready result. It replaces the file-driven stimulus path for on-chip and energy-measurement runs.

## Interface
- NUM_A, 8, features per frame (≥2)
- WIDTH_A, 4, bits per feature
- OUTWIDTH, 2, classifier result width
- SETTLE_CYCLES, 2, cycles `inp` is held stable before sampling `cls_out` (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- feat_valid  in  1  feature beat valid
- feat_data  in  WIDTH_A  feature value (unsigned)
- feat_last  in  1  marks final feature of a frame
- feat_ready  out  1  loader accepts a beat this cycle
- inp  out  NUM_A*WIDTH_A  to classifier; feature i occupies bits [(i+1)*WIDTH_A-1 : i*WIDTH_A]
- cls_out  in  OUTWIDTH  classifier output (combinational function of `inp`)
- res_valid  out  1  result valid
- res_data  out  OUTWIDTH  captured class
- res_ready  in  1  consumer accepts result
- err  out  1  sticky framing error

## Operation
- Beat accepted iff feat_valid && feat_ready on a clock edge.
- FSM states: LOAD, SETTLE, RESULT. Reset state is LOAD.
- LOAD:
  - feat_ready=1.
  - Accepted beat writes feat_data into slice idx of `inp`; idx increments (idx width ceil(log2 NUM_A)).
  - Accepted beat with idx==NUM_A-1: go to SETTLE, cnt=0, idx=0.
  - feat_last must coincide with idx==NUM_A-1.
  - Early last (feat_last=1, idx<NUM_A-1): beat is written, err<=1, idx<=0, stay in LOAD. The partial frame is discarded; its slices remain in `inp` until overwritten.
  - Missing last (feat_last=0 at idx==NUM_A-1): err<=1, frame proceeds to SETTLE normally.
- SETTLE:
  - feat_ready=0; `inp` unchanged.
  - cnt increments each cycle.
  - On the cycle where cnt==SETTLE_CYCLES-1: res_data<=cls_out, res_valid<=1, go to RESULT.
- RESULT:
  - feat_ready=0; res_valid and res_data held.
  - On res_valid && res_ready: res_valid<=0, go to LOAD.
- err is cleared only by rst.
- `inp` is never cleared between frames, only overwritten slice by slice. The classifier output is only sampled in SETTLE, so this is harmless.

## Timing
- Reset (rst high at an edge): state=LOAD, idx=0, cnt=0, inp=0, res_valid=0, res_data=0, err=0.
- feat_ready is 0 while rst is high and 1 from the first cycle after rst deasserts.
- Latency:
  - Last beat accepted in cycle c.
  - SETTLE occupies cycles c+1 … c+SETTLE_CYCLES.
  - cls_out is sampled at the edge ending cycle c+SETTLE_CYCLES.
  - res_valid is high from cycle c+SETTLE_CYCLES+1.
- Minimum frame period with continuous feat_valid and res_ready tied high: NUM_A+SETTLE_CYCLES+1 cycles. The first beat of the next frame is accepted the cycle after the result handshake.
- feat_valid gaps stall idx; there is no timeout.
- res_ready low holds RESULT indefinitely. res_data must not change while res_valid=1.
- rst mid-frame (any state) aborts immediately to reset values. No result is produced for the aborted frame.
- feat_valid asserted outside LOAD is ignored (not accepted, no error).

## Test plan
- Nominal frame: beats 1,2,…,8 with last on beat 8, cls_out driven 2'b10, res_ready=1.
  - Expect inp=32'h87654321 and res_valid high exactly SETTLE_CYCLES+1 cycles after the last beat.
  - Expect res_data=2'b10, err=0.
- Settle sampling: cls_out=2'b01 during the first SETTLE cycle, changed to 2'b11 before the sampling edge (SETTLE_CYCLES=2).
  - Expect res_data=2'b11.
- Back-pressure: res_ready held low 5 cycles after res_valid.
  - Expect res_valid/res_data stable and feat_ready=0 throughout.
  - Expect feat_ready=1 the cycle after the handshake.
- Early last: feat_last on beat 3, then a full 8-beat frame of 4'hF.
  - Expect err=1 after beat 3, no result for the partial frame.
  - Expect a result for the second frame with inp=32'hFFFFFFFF.
- Missing last: 8 beats with feat_last=0 throughout.
  - Expect err=1 and a normal result produced; err stays 1 on a following clean frame.
- Reset mid-SETTLE: assert rst for one cycle during SETTLE.
  - Expect inp=0, res_valid=0, err=0, and no result.
  - A subsequent frame completes normally.

Source files
------------

// File: rtl/feature_frame_loader.sv
`default_nettype none
// ============================================================================
// feature_frame_loader : packs a feature stream into a frame for the classifier,
// holds it while the classifier settles, then returns the sampled class.
// Rev 1.0
// ============================================================================
module feature_frame_loader #(
    parameter int NUM_A         = 8,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic                       feat_ready,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        cls_out,
    output logic                       res_valid,
    output logic [OUTWIDTH-1:0]        res_data,
    input  logic                       res_ready,
    output logic                       err
);

    localparam int IDX_W = $clog2(NUM_A);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(NUM_A - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_RESULT = 2'd2;

    logic [1:0]               r_state;
    logic [IDX_W-1:0]         r_idx;
    logic [CNT_W-1:0]         r_cnt;
    logic [NUM_A*WIDTH_A-1:0] r_inp;
    logic                     r_res_valid;
    logic [OUTWIDTH-1:0]      r_res_data;
    logic                     r_err;
    logic                     w_accept;

    // Ready is gated by rst so no beat can be taken during the reset cycle.
    assign feat_ready = (r_state == c_ST_LOAD) && !rst;
    assign w_accept   = feat_valid && feat_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_LOAD;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_inp       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_accept) begin
                        r_inp[int'(r_idx)*WIDTH_A +: WIDTH_A] <= feat_data;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_ST_SETTLE;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            if (!feat_last) begin
                                r_err <= 1'b1;
                            end
                        end else if (feat_last) begin
                            // Early last: drop the partial frame and restart.
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_ST_SETTLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_SETTLE_END) begin
                        r_res_data  <= cls_out;
                        r_res_valid <= 1'b1;
                        r_state     <= c_ST_RESULT;
                    end
                end
                c_ST_RESULT: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= c_ST_LOAD;
                    end
                end
                default: begin
                    r_state <= c_ST_LOAD;
                end
            endcase
        end
    end

    assign inp       = r_inp;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_feature_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_feature_frame_loader : directed vector bench for feature_frame_loader.
// Rev 1.0
// ============================================================================
module tb_feature_frame_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic [3:0]  feat_data;
    logic        feat_last;
    logic        feat_ready;
    logic [31:0] inp;
    logic [1:0]  cls_out;
    logic        res_valid;
    logic [1:0]  res_data;
    logic        res_ready;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    feature_frame_loader #(
        .NUM_A(8), .WIDTH_A(4), .OUTWIDTH(2), .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_data(feat_data), .feat_last(feat_last),
        .feat_ready(feat_ready), .inp(inp), .cls_out(cls_out),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fv;
        logic [3:0]  fd;
        logic        fl;
        logic [1:0]  co;
        logic        rr;
        logic        e_ready;
        logic        e_rvalid;
        logic [1:0]  e_rdata;
        logic        e_err;
        logic [31:0] e_inp;
    } vec_t;

    function automatic vec_t mk(input logic r, fv, input logic [3:0] fd, input logic fl,
                                input logic [1:0] co, input logic rr, input logic e_ready,
                                input logic e_rvalid, input logic [1:0] e_rdata,
                                input logic e_err, input logic [31:0] e_inp);
        vec_t v;
        v.rst = r; v.fv = fv; v.fd = fd; v.fl = fl; v.co = co; v.rr = rr;
        v.e_ready = e_ready; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
        v.e_err = e_err; v.e_inp = e_inp;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic set_in(input logic r, fv, input logic [3:0] fd, input logic fl,
                          input logic [1:0] co, input logic rr);
        @(negedge clk);
        rst = r; feat_valid = fv; feat_data = fd; feat_last = fl;
        cls_out = co; res_ready = rr;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic feed(input logic [31:0] frame, input int nbeats, input int last_pos,
                        input logic [1:0] co);
        for (int i = 0; i < nbeats; i++) begin
            set_in(1'b0, 1'b1, frame[i*4 +: 4], (i == last_pos), co, 1'b0);
            chk("feed_ready", {31'd0, feat_ready}, 32'd1);
            chk("feed_no_result", {31'd0, res_valid}, 32'd0);
        end
    endtask

    vec_t vt[13];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; feat_valid = 1'b0; feat_data = 4'h0; feat_last = 1'b0;
        cls_out = 2'b00; res_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Nominal frame, cycle by cycle: beats 1..8, last on beat 8.
        vt[0]  = mk(1, 0, 4'h0, 0, 2'b00, 0,  0, 0, 2'b00, 0, 32'h0000_0000);
        vt[1]  = mk(0, 1, 4'h1, 0, 2'b00, 0,  1, 0, 2'b00, 0, 32'h0000_0000);
        vt[2]  = mk(0, 1, 4'h2, 0, 2'b00, 0,  1, 0, 2'b00, 0, 32'h0000_0001);
        vt[3]  = mk(0, 1, 4'h3, 0, 2'b00, 0,  1, 0, 2'b00, 0, 32'h0000_0021);
        vt[4]  = mk(0, 1, 4'h4, 0, 2'b00, 0,  1, 0, 2'b00, 0, 32'h0000_0321);
        vt[5]  = mk(0, 1, 4'h5, 0, 2'b00, 0,  1, 0, 2'b00, 0, 32'h0000_4321);
        vt[6]  = mk(0, 1, 4'h6, 0, 2'b00, 0,  1, 0, 2'b00, 0, 32'h0005_4321);
        vt[7]  = mk(0, 1, 4'h7, 0, 2'b00, 0,  1, 0, 2'b00, 0, 32'h0065_4321);
        vt[8]  = mk(0, 1, 4'h8, 1, 2'b10, 0,  1, 0, 2'b00, 0, 32'h0765_4321);
        vt[9]  = mk(0, 1, 4'h9, 0, 2'b10, 1,  0, 0, 2'b00, 0, 32'h8765_4321);
        vt[10] = mk(0, 0, 4'h0, 0, 2'b10, 1,  0, 0, 2'b00, 0, 32'h8765_4321);
        vt[11] = mk(0, 0, 4'h0, 0, 2'b00, 1,  0, 1, 2'b10, 0, 32'h8765_4321);
        vt[12] = mk(0, 0, 4'h0, 0, 2'b00, 1,  1, 0, 2'b10, 0, 32'h8765_4321);

        for (int k = 0; k < 13; k++) begin
            set_in(vt[k].rst, vt[k].fv, vt[k].fd, vt[k].fl, vt[k].co, vt[k].rr);
            chk($sformatf("vec%0d_feat_ready", k), {31'd0, feat_ready}, {31'd0, vt[k].e_ready});
            chk($sformatf("vec%0d_res_valid", k), {31'd0, res_valid}, {31'd0, vt[k].e_rvalid});
            chk($sformatf("vec%0d_res_data", k), {30'd0, res_data}, {30'd0, vt[k].e_rdata});
            chk($sformatf("vec%0d_err", k), {31'd0, err}, {31'd0, vt[k].e_err});
            chk($sformatf("vec%0d_inp", k), inp, vt[k].e_inp);
        end

        // Settle sampling: class changes between the two settle cycles.
        feed(32'h3333_3333, 8, 7, 2'b01);
        set_in(0, 0, 4'h0, 0, 2'b01, 0);
        chk("settle1_ready", {31'd0, feat_ready}, 32'd0);
        set_in(0, 0, 4'h0, 0, 2'b11, 0);
        set_in(0, 0, 4'h0, 0, 2'b00, 1);
        chk("settle_res_valid", {31'd0, res_valid}, 32'd1);
        chk("settle_res_data", {30'd0, res_data}, 32'd3);

        // Back-pressure: result held for 5 cycles with res_ready low.
        set_in(0, 0, 4'h0, 0, 2'b00, 0);
        chk("bp_pre_ready", {31'd0, feat_ready}, 32'd1);
        feed(32'hC0FF_EE12, 8, 7, 2'b01);
        set_in(0, 1, 4'hA, 0, 2'b01, 0);
        set_in(0, 1, 4'hA, 0, 2'b01, 0);
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 4'hA, 0, 2'b10, 0);
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_data", {30'd0, res_data}, 32'd1);
            chk("bp_feat_ready", {31'd0, feat_ready}, 32'd0);
            chk("bp_inp", inp, 32'hC0FF_EE12);
        end
        set_in(0, 0, 4'h0, 0, 2'b10, 1);
        chk("bp_hs_valid", {31'd0, res_valid}, 32'd1);
        set_in(0, 0, 4'h0, 0, 2'b10, 0);
        chk("bp_after_ready", {31'd0, feat_ready}, 32'd1);
        chk("bp_after_valid", {31'd0, res_valid}, 32'd0);
        chk("bp_after_data", {30'd0, res_data}, 32'd1);
        chk("bp_after_err", {31'd0, err}, 32'd0);

        // Early last on beat 3, then a full frame of 4'hF.
        set_in(1, 0, 4'h0, 0, 2'b00, 0);
        feed(32'h0000_0321, 3, 2, 2'b00);
        set_in(0, 0, 4'h0, 0, 2'b00, 0);
        chk("early_err", {31'd0, err}, 32'd1);
        chk("early_ready", {31'd0, feat_ready}, 32'd1);
        chk("early_no_result", {31'd0, res_valid}, 32'd0);
        feed(32'hFFFF_FFFF, 8, 7, 2'b10);
        set_in(0, 0, 4'h0, 0, 2'b10, 0);
        chk("early_inp", inp, 32'hFFFF_FFFF);
        set_in(0, 0, 4'h0, 0, 2'b10, 0);
        set_in(0, 0, 4'h0, 0, 2'b00, 1);
        chk("early_res_valid", {31'd0, res_valid}, 32'd1);
        chk("early_res_data", {30'd0, res_data}, 32'd2);

        // Missing last: error flagged, result still produced; err sticky.
        set_in(1, 0, 4'h0, 0, 2'b00, 0);
        feed(32'h1234_5678, 8, -1, 2'b01);
        set_in(0, 0, 4'h0, 0, 2'b01, 0);
        chk("miss_err", {31'd0, err}, 32'd1);
        set_in(0, 0, 4'h0, 0, 2'b01, 0);
        set_in(0, 0, 4'h0, 0, 2'b00, 1);
        chk("miss_res_valid", {31'd0, res_valid}, 32'd1);
        chk("miss_res_data", {30'd0, res_data}, 32'd1);
        feed(32'h8765_4321, 8, 7, 2'b11);
        set_in(0, 0, 4'h0, 0, 2'b11, 0);
        set_in(0, 0, 4'h0, 0, 2'b11, 0);
        set_in(0, 0, 4'h0, 0, 2'b00, 1);
        chk("clean_res_valid", {31'd0, res_valid}, 32'd1);
        chk("clean_res_data", {30'd0, res_data}, 32'd3);
        chk("clean_err_sticky", {31'd0, err}, 32'd1);

        // Reset during SETTLE aborts the frame and clears err.
        feed(32'hDEAD_BEEF, 8, 7, 2'b10);
        set_in(0, 0, 4'h0, 0, 2'b10, 1);
        set_in(1, 0, 4'h0, 0, 2'b10, 1);
        chk("rst_ready_low", {31'd0, feat_ready}, 32'd0);
        set_in(0, 0, 4'h0, 0, 2'b10, 1);
        chk("rst_inp", inp, 32'h0000_0000);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, feat_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 4'h0, 0, 2'b10, 1);
            chk("rst_no_result", {31'd0, res_valid}, 32'd0);
        end
        feed(32'h1111_2222, 8, 7, 2'b01);
        set_in(0, 0, 4'h0, 0, 2'b01, 0);
        set_in(0, 0, 4'h0, 0, 2'b01, 0);
        set_in(0, 0, 4'h0, 0, 2'b00, 1);
        chk("post_rst_valid", {31'd0, res_valid}, 32'd1);
        chk("post_rst_data", {30'd0, res_data}, 32'd1);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        chk("post_rst_inp", inp, 32'h1111_2222);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
